// File: rtl/piece_bag_gen_pkg.sv
// Shared types and constants for the tetromino piece generator.
package piece_bag_gen_pkg;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Classic seven block families A..G map onto kind codes 0..6.
  typedef enum logic [2:0] {
    PIECE_A = 3'd0,
    PIECE_B = 3'd1,
    PIECE_C = 3'd2,
    PIECE_D = 3'd3,
    PIECE_E = 3'd4,
    PIECE_F = 3'd5,
    PIECE_G = 3'd6
  } piece_kind_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } gen_state_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/piece_bag_gen_lfsr16.sv
// 16-bit right-shifting Galois LFSR with enable and synchronous load.
module lfsr16
  import piece_bag_gen_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] value
);

  logic [15:0] state_q;

  // An all-zero state would lock the LFSR, so a zero load falls back to SEED.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEED;
    end else if (load) begin
      state_q <= (load_val == 16'h0000) ? SEED : load_val;
    end else if (en) begin
      state_q <= lfsr_step(state_q);
    end
  end

  assign value = state_q;

endmodule

// File: rtl/piece_bag_gen.sv
// Tetromino source: LFSR-driven bag or random draws into a head+preview shift queue.
module piece_bag_gen
  import piece_bag_gen_pkg::*;
#(
  parameter int          NUM_KINDS     = 7,
  parameter int          PREVIEW_DEPTH = 3,
  parameter int          BAG_MODE      = 1,
  parameter logic [15:0] SEED          = 16'hACE1,
  localparam int         KW            = $clog2(NUM_KINDS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        pop_req,
  input  logic                        reseed,
  input  logic [15:0]                 seed_in,
  output logic                        piece_valid,
  output logic [KW-1:0]               piece_kind,
  output logic [PREVIEW_DEPTH*KW-1:0] preview,
  output logic [2:0]                  preview_count,
  output logic [3:0]                  bag_count
);

  localparam int          Q         = PREVIEW_DEPTH + 1;
  localparam logic [2:0]  Q_OCC     = 3'(Q);
  localparam logic [15:0] KIND_MASK = 16'((1 << KW) - 1);

  logic [15:0]          lfsr_val;
  logic [KW-1:0]        queue_q [Q];
  logic [KW-1:0]        queue_d [Q];
  logic [2:0]           occ_q, occ_d, occ_after_pop;
  logic [NUM_KINDS-1:0] mask_q, mask_d, mask_set;
  gen_state_t           state_q, state_d;
  logic                 pop, draw;
  logic [KW-1:0]        pick;
  logic                 found;
  int                   cand, idx;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .load     (reseed),
    .load_val (seed_in),
    .value    (lfsr_val)
  );

  // Kind selection: bag mode walks upward (wrapping) from the candidate to the first unused kind.
  always_comb begin
    cand  = int'(lfsr_val & KIND_MASK) % NUM_KINDS;
    pick  = KW'(cand);
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_KINDS; k++) begin
      idx = (cand + k) % NUM_KINDS;
      if (!found && (BAG_MODE == 0 || !mask_q[KW'(idx)])) begin
        pick  = KW'(idx);
        found = 1'b1;
      end
    end
    mask_set       = mask_q;
    mask_set[pick] = 1'b1;
  end

  // Reseed wins over everything; a pop frees its slot so the same edge can refill it.
  always_comb begin
    pop           = pop_req && (occ_q != 3'd0) && !reseed;
    occ_after_pop = occ_q - {2'b00, pop};
    draw          = en && !reseed && (occ_after_pop < Q_OCC);

    for (int i = 0; i < Q - 1; i++) begin
      queue_d[i] = pop ? queue_q[i+1] : queue_q[i];
    end
    queue_d[Q-1] = pop ? '0 : queue_q[Q-1];
    for (int i = 0; i < Q; i++) begin
      if (draw && occ_after_pop == 3'(i)) begin
        queue_d[i] = pick;
      end
    end

    occ_d  = occ_after_pop + {2'b00, draw};
    mask_d = mask_q;
    if (draw && BAG_MODE != 0) begin
      mask_d = (mask_set == '1) ? '0 : mask_set;
    end

    if (reseed) begin
      for (int i = 0; i < Q; i++) begin
        queue_d[i] = '0;
      end
      occ_d  = 3'd0;
      mask_d = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = FILL;
      FILL:    if (occ_d == Q_OCC) state_d = FULL;
      FULL:    if (pop) state_d = FILL;
      default: state_d = IDLE;
    endcase
    if (reseed) begin
      state_d = FILL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Q; i++) begin
        queue_q[i] <= '0;
      end
      occ_q   <= 3'd0;
      mask_q  <= '0;
      state_q <= IDLE;
    end else begin
      for (int i = 0; i < Q; i++) begin
        queue_q[i] <= queue_d[i];
      end
      occ_q   <= occ_d;
      mask_q  <= mask_d;
      state_q <= state_d;
    end
  end

  // Unused slots always hold zero, so preview entries past the count read 0.
  always_comb begin
    preview = '0;
    for (int i = 0; i < PREVIEW_DEPTH; i++) begin
      preview[i*KW +: KW] = queue_q[i+1];
    end
    bag_count = 4'd0;
    for (int i = 0; i < NUM_KINDS; i++) begin
      bag_count = bag_count + {3'b000, mask_q[i]};
    end
  end

  assign piece_valid   = (occ_q != 3'd0);
  assign piece_kind    = queue_q[0];
  assign preview_count = (occ_q == 3'd0) ? 3'd0 : occ_q - 3'd1;

endmodule
